mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencing controller for the single shared memory port. It arbitrates between instruction fetch and data load/store. It drives the select of the port's 32-bit 2-to-1 address/write-data steering, runs a req/ready handshake with the memory, and returns per-requester done pulses with registered read data. It sits between the fetch stage, the load/store unit and the memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; range 1..15
- TIMEOUT, 16, BUSY cycles without mem_ready before forced error completion; range 2..255
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle data completion pulse
- rdata  out  DATA_W  registered read data; valid with a done pulse
- err  out  1  timeout flag; valid with a done pulse
- sel  out  1  steering select: 0 = fetch, 1 = data
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  steered address
- mem_wdata  out  DATA_W  steered write data (d_wdata)
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready
- mem_ready  in  1  memory completion, single cycle
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: register the winner into sel, go to BUSY.
- Winner rule:
  - Only one request: that requester wins.
  - Both request: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) on a data grant when if_req is also high.
  - Clears on any fetch grant.
- BUSY:
  - mem_req = 1.
  - mem_we = d_we when sel = 1, otherwise 0.
  - mem_addr / mem_wdata steered by sel.
  - On mem_ready: latch mem_rdata into rdata, err = 0, go to RESP.
  - On timer == TIMEOUT-1 without mem_ready: rdata = 0, err = 1, go to RESP.
- RESP:
  - Pulse if_done (sel = 0) or d_done (sel = 1) for exactly one cycle.
  - Return to IDLE.
- Outside BUSY: mem_req = 0 and mem_we = 0. mem_addr follows sel as a don't-care.
- Stores also produce a done pulse; rdata is then whatever mem_rdata carried.
- A requester may re-raise req in the cycle after its done. It is sampled in IDLE, so no access is served twice.
- Request inputs are ignored in BUSY and RESP.
- Address and write-data inputs are steered live, not latched. Requesters must hold them stable until done.

## Timing
- Reset values: IDLE, sel = 0, mem_req = 0, mem_we = 0, if_done = 0, d_done = 0, rdata = 0, err = 0, busy = 0, starve_cnt = 0, timer = 0.
- Minimum access: 3 cycles (IDLE grant, BUSY with mem_ready, RESP). Maximum: TIMEOUT + 2 cycles.
- Done pulse appears one cycle after the mem_ready cycle.
- Back-to-back throughput: one access per 3 cycles.
- mem_ready outside BUSY is ignored.
- rst asserted mid-access: all outputs return to reset values immediately and asynchronously. No done pulse is issued; the requester re-issues.
- timer clears on entry to BUSY.

## Structure
- Shared header/package holds:
  - state encodings ST_IDLE, ST_BUSY, ST_RESP
  - select constants SEL_IF = 0, SEL_D = 1
- Sub-module mem_steer (combinational) contains:
  - the two 32-bit 2-to-1 selects (address, write data)
  - the we gating
- The FSM, starvation counter and timeout timer live in mem_port_arbiter.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x0040_0000, mem_ready one cycle after mem_req with mem_rdata = 0x2408_0005 -> mem_addr = 0x0040_0000, mem_we = 0, if_done pulses once with rdata = 0x2408_0005, err = 0.
- Simultaneous requests: if_req = d_req = 1, d_we = 1, d_addr = 0x1001_0000, d_wdata = 0xDEAD_BEEF -> data served first (sel = 1, mem_we = 1, mem_wdata = 0xDEAD_BEEF), then fetch.
- Starvation: d_req held continuously re-requesting with if_req = 1, STARVE_MAX = 4 -> exactly 4 d_done pulses, then 1 if_done, then data resumes.
- Timeout: mem_ready never asserted, TIMEOUT = 16 -> done pulse with err = 1, rdata = 0; busy lasts 17 cycles.
- Reset mid-BUSY: assert rst while mem_req = 1 -> mem_req and busy fall without a clock edge; no done pulse; after release, a fresh request completes normally.
- Stray mem_ready in IDLE with mem_rdata = 0xFFFF_FFFF -> rdata stays unchanged, no done pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, steering selects
// and the arbitration rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_D  = 1'b1;

  // Data has priority unless fetch has been passed over STARVE_MAX times.
  function automatic logic pick_winner(input logic if_req, input logic d_req,
                                       input logic starved);
    return (d_req && !(if_req && starved)) ? SEL_D : SEL_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              sel;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_done, d_done, rdata, err, sel, mem_req, mem_we, mem_addr,
           mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_done, d_done, rdata, err, sel, mem_req, mem_we, mem_addr,
           mem_wdata, busy
  );
endinterface

// File: rtl/mem_steer.sv
// Combinational address/write-data steering and write-enable gating for the
// shared memory port.
module mem_steer
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              active,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  assign mem_addr  = (sel == SEL_D) ? d_addr : if_addr;
  // Fetch never writes, so its write-data leg is tied off.
  assign mem_wdata = (sel == SEL_D) ? d_wdata : '0;
  assign mem_we    = active && (sel == SEL_D) && d_we;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory-port sequencer: arbitrates fetch vs data, runs the req/ready
// handshake with a timeout, and returns per-requester done pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [3:0]        starve_q, starve_d;
  logic [7:0]        timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              any_req, winner, in_busy, if_done_o, d_done_o, busy_o;

  assign any_req = bus.if_req || bus.d_req;
  assign winner  = pick_winner(bus.if_req, bus.d_req, starve_q == STARVE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: if (bus.mem_ready || timer_q == TMO_LAST) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_busy   = (state_q == ST_BUSY);
    busy_o    = (state_q != ST_IDLE);
    if_done_o = (state_q == ST_RESP) && (sel_q == SEL_IF);
    d_done_o  = (state_q == ST_RESP) && (sel_q == SEL_D);
  end

  always_comb begin
    sel_d    = sel_q;
    starve_d = starve_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (state_q == ST_IDLE && any_req) begin
      sel_d   = winner;
      timer_d = '0;
      // Only data grants that actually bypass a waiting fetch count as starvation.
      if (winner == SEL_IF)
        starve_d = '0;
      else if (bus.if_req && starve_q != STARVE_LIM)
        starve_d = starve_q + 4'd1;
    end
    if (in_busy) begin
      timer_d = timer_q + 8'd1;
      if (bus.mem_ready) begin
        rdata_d = bus.mem_rdata;
        err_d   = 1'b0;
      end else if (timer_q == TMO_LAST) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= SEL_IF;
      starve_q <= '0;
      timer_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  mem_steer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_steer (
    .sel       (sel_q),
    .active    (in_busy),
    .d_we      (bus.d_we),
    .if_addr   (bus.if_addr),
    .d_addr    (bus.d_addr),
    .d_wdata   (bus.d_wdata),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_we    (bus.mem_we)
  );

  assign bus.sel     = sel_q;
  assign bus.mem_req = in_busy;
  assign bus.busy    = busy_o;
  assign bus.if_done = if_done_o;
  assign bus.d_done  = d_done_o;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

endmodule
